// File: rtl/muller_c_pipe.sv
// Clocked 4-phase Muller C-element micropipeline: NCH request channels are joined into one stage-0 C-element, which feeds STAGES stages of bundled data.
// Optional registered protocol checker is built only when MULLER_C_PIPE_PROTO_CHK_EN is defined.

module muller_c_stage #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          all_one,
  input  logic          all_zero,
  input  logic [DW-1:0] din,
  output logic          c,
  output logic [DW-1:0] d
);
  // Data is captured only on the 0->1 edge of c; on every other edge it holds.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      c <= 1'b0;
      d <= '0;
    end else if (all_one) begin
      c <= 1'b1;
      if (!c) d <= din;
    end else if (all_zero) begin
      c <= 1'b0;
    end
  end
endmodule

module muller_c_pipe #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 8,
  parameter int NCH    = 2
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_req,
  output logic                 in_ack,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 proto_err
);
  localparam int DW = NCH * WIDTH;

  logic [STAGES-1:0]         c;
  logic [STAGES-1:0]         fwd_one, fwd_zero, bwd_n;
  logic [STAGES-1:0]         all_one, all_zero;
  logic [STAGES-1:0][DW-1:0] d, din;

  // A stage fires high when every input is 1 and low when every input is 0.
  assign all_one  = fwd_one & bwd_n;
  assign all_zero = fwd_zero & ~bwd_n;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign fwd_one[i]  = &in_req;
      assign fwd_zero[i] = ~|in_req;
      assign din[i]      = in_data;
    end else begin : g_body
      assign fwd_one[i]  = c[i-1];
      assign fwd_zero[i] = ~c[i-1];
      assign din[i]      = d[i-1];
    end
    if (i == STAGES-1) begin : g_tail
      assign bwd_n[i] = ~out_ack;
    end else begin : g_mid
      assign bwd_n[i] = ~c[i+1];
    end
    muller_c_stage #(.DW(DW)) u_stg (
      .clock    (clock),
      .rst_n    (rst_n),
      .all_one  (all_one[i]),
      .all_zero (all_zero[i]),
      .din      (din[i]),
      .c        (c[i]),
      .d        (d[i])
    );
  end

  assign in_ack   = c[0];
  assign out_req  = c[STAGES-1];
  assign out_data = d[STAGES-1];

`ifdef MULLER_C_PIPE_PROTO_CHK_EN
  logic [NCH-1:0] req_q, data_chg;
  logic [DW-1:0]  data_q;
  logic           ack_q, armed, err;
  logic           viol_req, viol_data, viol_ack;

  for (genvar k = 0; k < NCH; k++) begin : g_chg
    assign data_chg[k] = in_data[k*WIDTH +: WIDTH] != data_q[k*WIDTH +: WIDTH];
  end

  // A request may only move while it equals in_ack; out_ack may only move while it differs from out_req.
  assign viol_req  = |((in_req ^ req_q) & (req_q ^ {NCH{in_ack}}));
  assign viol_data = |(data_chg & req_q & ~{NCH{in_ack}});
  assign viol_ack  = (out_ack ^ ack_q) & ~(ack_q ^ out_req);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      data_q <= '0;
      ack_q  <= 1'b0;
      armed  <= 1'b0;
      err    <= 1'b0;
    end else begin
      req_q  <= in_req;
      data_q <= in_data;
      ack_q  <= out_ack;
      armed  <= 1'b1;
      if (armed && (viol_req || viol_data || viol_ack)) err <= 1'b1;
    end
  end

  assign proto_err = err;
`else
  assign proto_err = 1'b0;
`endif

endmodule
